// File: rtl/sb_pkg.sv
// Sideband link definitions shared by the transmitter and receiver.
// Holds the framing constants and the receive FSM state type.
package sb_pkg;

  localparam int SB_PKT_BITS   = 64;
  localparam int SB_GAP_CYCLES = 32;
  localparam int SB_BIT_CNT_W  = $clog2(SB_PKT_BITS);
  localparam int SB_GAP_CNT_W  = $clog2(SB_GAP_CYCLES);

  typedef logic [SB_PKT_BITS-1:0] sb_word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    GAP       = 2'd2
  } sb_rx_state_e;

endpackage

// File: rtl/sb_rx_fifo.sv
// Receive FIFO for completed sideband words; head word is shown combinationally.
// Occupancy counter is one bit wider than the indices so full and empty stay distinct.
module sb_rx_fifo
  import sb_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic     clk_800MHz,
  input  logic     reset,
  input  logic     push,
  input  sb_word_t push_data,
  input  logic     pop,
  output sb_word_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int IDX_W = $clog2(depth);
  localparam int CNT_W = IDX_W + 1;

  sb_word_t         mem [depth];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (count == CNT_W'(depth));
  assign empty = (count == '0);

  // A pop frees the slot this edge, so a push into a full FIFO is still accepted.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_idx <= wr_idx + 1'b1;
      if (pop_ok)  rd_idx <= rd_idx + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_800MHz) begin
    if (push_ok) mem[wr_idx] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_idx];

endmodule

// File: rtl/sb_rx_deser.sv
// Sideband receiver: detects the start marker on the forwarded clock pin, assembles
// a 64-bit word LSB first, waits out the inter-packet gap and queues words in a FIFO.
module sb_rx_deser
  import sb_pkg::*;
#(
  parameter int buffer_size = 4
) (
  input  logic        clk_800MHz,
  input  logic        reset,
  input  logic        dataPin_i,
  input  logic        clkPin_i,
  input  logic        enable_i,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o
);

  localparam logic [SB_BIT_CNT_W-1:0] BIT_LAST = SB_BIT_CNT_W'(SB_PKT_BITS - 1);
  localparam logic [SB_GAP_CNT_W-1:0] GAP_LAST = SB_GAP_CNT_W'(SB_GAP_CYCLES - 1);

  sb_rx_state_e            state;
  sb_rx_state_e            state_n;
  logic [SB_BIT_CNT_W-1:0] bit_cnt;
  logic [SB_BIT_CNT_W-1:0] bit_cnt_n;
  logic [SB_GAP_CNT_W-1:0] gap_cnt;
  logic [SB_GAP_CNT_W-1:0] gap_cnt_n;
  sb_word_t                shift_word;
  sb_word_t                word_next;
  logic                    word_done;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (clkPin_i) begin
          state_n   = RECEIVING;
          bit_cnt_n = '0;
        end
      end
      RECEIVING: begin
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) begin
          word_done = 1'b1;
          state_n   = GAP;
          gap_cnt_n = '0;
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          // The last gap edge doubles as the start marker of a back-to-back packet.
          gap_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = clkPin_i ? RECEIVING : IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        gap_cnt_n = '0;
      end
    endcase
  end

  // The completing bit is merged combinationally so the word is pushed on its own edge.
  always_comb begin
    word_next          = shift_word;
    word_next[bit_cnt] = dataPin_i;
  end

  always_ff @(posedge clk_800MHz) begin
    if (state == RECEIVING) shift_word <= word_next;
  end

  assign pop  = ~empty & ready_i;
  assign push = word_done & enable_i & (~full | pop);

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      overflow_o <= 1'b0;
    end else if (word_done && enable_i && full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

  sb_rx_fifo #(
    .depth (buffer_size)
  ) u_fifo (
    .clk_800MHz (clk_800MHz),
    .reset      (reset),
    .push       (push),
    .push_data  (word_next),
    .pop        (pop),
    .pop_data   (data_o),
    .full       (full),
    .empty      (empty)
  );

  assign valid_o = ~empty;

endmodule
